// File: rtl/dual_issue_scheduler_pkg.sv
// Shared definitions for the dual-issue scheduler: instruction encodings,
// FSM state encoding and the per-slot register-usage record.
package dual_issue_scheduler_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] FUNCT_JR = 6'h08;
  localparam logic [4:0] REG_RA   = 5'd31;

  typedef enum logic {
    S_PAIR   = 1'b0,
    S_SECOND = 1'b1
  } state_t;

  typedef struct packed {
    logic [4:0] dest;
    logic       dest_en;
    logic [4:0] src_a;
    logic       src_a_en;
    logic [4:0] src_b;
    logic       src_b_en;
    logic       is_mem;
    logic       is_load;
    logic       is_ctrl;
  } usage_t;

  // Enables already exclude register 0, so a plain compare is hazard-safe.
  function automatic logic reads_reg(usage_t u, logic [4:0] r);
    return (u.src_a_en && (u.src_a == r)) || (u.src_b_en && (u.src_b == r));
  endfunction

endpackage

// File: rtl/dual_issue_scheduler_if.sv
// Fetch-pair handshake, lane issue signals and performance counters
// between the fetch pair buffer and the scheduler.
interface dual_issue_scheduler_if #(parameter int CNT_W = 16);
  logic             in_valid;
  logic             in_ready;
  logic [5:0]       opcode1, funct1, opcode2, funct2;
  logic [4:0]       rs1, rt1, rd1, rs2, rt2, rd2;
  logic             stall_in;
  logic             flush;
  logic             laneA_valid;
  logic             laneA_sel;
  logic             laneB_valid;
  logic             bubble;
  logic [CNT_W-1:0] pair_cnt, split_cnt, bubble_cnt;

  modport master (
    output in_valid, opcode1, funct1, rs1, rt1, rd1,
           opcode2, funct2, rs2, rt2, rd2, stall_in, flush,
    input  in_ready, laneA_valid, laneA_sel, laneB_valid, bubble,
           pair_cnt, split_cnt, bubble_cnt
  );

  modport slave (
    input  in_valid, opcode1, funct1, rs1, rt1, rd1,
           opcode2, funct2, rs2, rt2, rd2, stall_in, flush,
    output in_ready, laneA_valid, laneA_sel, laneB_valid, bubble,
           pair_cnt, split_cnt, bubble_cnt
  );
endinterface

// File: rtl/dual_issue_scheduler_reg_usage_decode.sv
// Combinational register-usage decode of one instruction slot: which
// register it writes, which it reads, and its memory/control class.
module reg_usage_decode
  import dual_issue_scheduler_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic [4:0] rd,
  output logic [4:0] dest,
  output logic       dest_en,
  output logic [4:0] src_a,
  output logic       src_a_en,
  output logic [4:0] src_b,
  output logic       src_b_en,
  output logic       is_mem,
  output logic       is_load,
  output logic       is_ctrl
);
  logic wr_en, rd_a_en, rd_b_en;

  assign src_a = rs;
  assign src_b = rt;

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    dest    = '0;
    wr_en   = 1'b0;
    rd_a_en = 1'b0;
    rd_b_en = 1'b0;
    is_mem  = 1'b0;
    is_load = 1'b0;
    is_ctrl = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        rd_a_en = 1'b1;
        if (funct == FUNCT_JR) begin
          is_ctrl = 1'b1;
        end else begin
          dest    = rd;
          wr_en   = 1'b1;
          rd_b_en = 1'b1;
        end
      end
      OP_ADDI: begin
        dest    = rt;
        wr_en   = 1'b1;
        rd_a_en = 1'b1;
      end
      OP_LW: begin
        dest    = rt;
        wr_en   = 1'b1;
        rd_a_en = 1'b1;
        is_mem  = 1'b1;
        is_load = 1'b1;
      end
      OP_SW: begin
        rd_a_en = 1'b1;
        rd_b_en = 1'b1;
        is_mem  = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        rd_a_en = 1'b1;
        rd_b_en = 1'b1;
        is_ctrl = 1'b1;
      end
      OP_J:   is_ctrl = 1'b1;
      OP_JAL: begin
        dest    = REG_RA;
        wr_en   = 1'b1;
        is_ctrl = 1'b1;
      end
      default: ;
    endcase
  end

  // Register 0 is hardwired, so it never takes part in a hazard.
  assign dest_en  = wr_en   && (dest  != 5'd0);
  assign src_a_en = rd_a_en && (rs    != 5'd0);
  assign src_b_en = rd_b_en && (rt    != 5'd0);
endmodule

// File: rtl/dual_issue_scheduler.sv
// Dual-issue scheduler: issues the fetched pair together, split over two
// cycles, or inserts a load-use bubble; keeps wrap-around perf counters.
module dual_issue_scheduler
  import dual_issue_scheduler_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input logic                  clk,
  input logic                  rst,
  dual_issue_scheduler_if.slave bus
);
  usage_t u1, u2;

  reg_usage_decode dec1 (
    .opcode(bus.opcode1), .funct(bus.funct1), .rs(bus.rs1), .rt(bus.rt1), .rd(bus.rd1),
    .dest(u1.dest), .dest_en(u1.dest_en), .src_a(u1.src_a), .src_a_en(u1.src_a_en),
    .src_b(u1.src_b), .src_b_en(u1.src_b_en), .is_mem(u1.is_mem), .is_load(u1.is_load),
    .is_ctrl(u1.is_ctrl)
  );

  reg_usage_decode dec2 (
    .opcode(bus.opcode2), .funct(bus.funct2), .rs(bus.rs2), .rt(bus.rt2), .rd(bus.rd2),
    .dest(u2.dest), .dest_en(u2.dest_en), .src_a(u2.src_a), .src_a_en(u2.src_a_en),
    .src_b(u2.src_b), .src_b_en(u2.src_b_en), .is_mem(u2.is_mem), .is_load(u2.is_load),
    .is_ctrl(u2.is_ctrl)
  );

  state_t           state, next_state;
  logic             ld_valid;
  logic [4:0]       ld_dest;
  logic [CNT_W-1:0] pair_cnt, split_cnt, bubble_cnt;

  logic haz1, haz2, conflict, ld1, ld2;
  logic a_valid, a_sel, b_valid, ready, bub, ld_hit;
  logic [4:0] ld_hit_dest;

  assign haz1 = ld_valid && reads_reg(u1, ld_dest);
  assign haz2 = ld_valid && reads_reg(u2, ld_dest);
  assign ld1  = u1.is_load && u1.dest_en;
  assign ld2  = u2.is_load && u2.dest_en;
  assign conflict = (u1.dest_en && (reads_reg(u2, u1.dest) ||
                                    (u2.dest_en && (u2.dest == u1.dest))))
                  || (u1.is_mem && u2.is_mem) || u1.is_ctrl;

  always_comb begin
    a_valid     = 1'b0;
    a_sel       = 1'b0;
    b_valid     = 1'b0;
    ready       = 1'b0;
    bub         = 1'b0;
    ld_hit      = 1'b0;
    ld_hit_dest = ld_dest;
    next_state  = state;
    if (bus.flush) begin
      ready      = 1'b1;
      next_state = S_PAIR;
    end else if (!bus.stall_in) begin
      case (state)
        S_PAIR: if (bus.in_valid) begin
          if (haz1) begin
            bub = 1'b1;
          end else if (!conflict && !haz2) begin
            a_valid     = 1'b1;
            b_valid     = 1'b1;
            ready       = 1'b1;
            ld_hit      = ld1 || ld2;
            ld_hit_dest = ld1 ? u1.dest : u2.dest;
          end else begin
            a_valid     = 1'b1;
            next_state  = S_SECOND;
            ld_hit      = ld1;
            ld_hit_dest = u1.dest;
          end
        end
        S_SECOND: begin
          if (haz2) begin
            bub = 1'b1;
          end else begin
            a_valid     = 1'b1;
            a_sel       = 1'b1;
            ready       = 1'b1;
            next_state  = S_PAIR;
            ld_hit      = ld2;
            ld_hit_dest = u2.dest;
          end
        end
        default: next_state = S_PAIR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_PAIR;
      ld_valid   <= 1'b0;
      ld_dest    <= '0;
      pair_cnt   <= '0;
      split_cnt  <= '0;
      bubble_cnt <= '0;
    end else if (bus.flush) begin
      state    <= S_PAIR;
      ld_valid <= 1'b0;
    end else if (!bus.stall_in) begin
      // NOTE: sequential state uses non-blocking assignments only.
      state    <= next_state;
      ld_valid <= ld_hit;
      ld_dest  <= ld_hit_dest;
      if (a_valid && b_valid) pair_cnt   <= pair_cnt + 1'b1;
      if (a_valid && a_sel)   split_cnt  <= split_cnt + 1'b1;
      if (bub)                bubble_cnt <= bubble_cnt + 1'b1;
    end
  end

  assign bus.laneA_valid = a_valid;
  assign bus.laneA_sel   = a_sel;
  assign bus.laneB_valid = b_valid;
  assign bus.in_ready    = ready;
  assign bus.bubble      = bub;
  assign bus.pair_cnt    = pair_cnt;
  assign bus.split_cnt   = split_cnt;
  assign bus.bubble_cnt  = bubble_cnt;
endmodule
